// File: rtl/axi_read_scheduler_if.sv
// rtl/axi_read_scheduler_if.sv - AR/R handshake bundle between the read scheduler and the interconnect
//
// Purpose: groups the master/slave AR and R handshake signals observed by the
// read scheduler together with the select/gating strobes it drives.
// Modports:
//   slave  - scheduler side: samples master/slave handshakes, drives strobes
//   master - interconnect/bench side: drives handshakes, observes strobes
interface axi_read_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
);
  logic              ARVALID_M0, ARVALID_M1;
  logic [ADDR_W-1:0] ARADDR_M0,  ARADDR_M1;
  logic [LEN_W-1:0]  ARLEN_M0,   ARLEN_M1;
  logic              ARREADY_S0, ARREADY_S1;
  logic              RVALID_S0,  RLAST_S0;
  logic              RVALID_S1,  RLAST_S1;
  logic              RREADY_M0,  RREADY_M1;

  logic              ARREADY_M0, ARREADY_M1;
  logic [1:0]        ar_gnt;
  logic [1:0]        ar_valid_s;
  logic              r_mst;
  logic [1:0]        r_src;
  logic              r_busy;
  logic              dflt_rvalid, dflt_rlast;

  modport slave (
    input  ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
    input  ARREADY_S0, ARREADY_S1, RVALID_S0, RLAST_S0, RVALID_S1, RLAST_S1,
    input  RREADY_M0, RREADY_M1,
    output ARREADY_M0, ARREADY_M1, ar_gnt, ar_valid_s, r_mst, r_src, r_busy,
    output dflt_rvalid, dflt_rlast
  );

  modport master (
    output ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
    output ARREADY_S0, ARREADY_S1, RVALID_S0, RLAST_S0, RVALID_S1, RLAST_S1,
    output RREADY_M0, RREADY_M1,
    input  ARREADY_M0, ARREADY_M1, ar_gnt, ar_valid_s, r_mst, r_src, r_busy,
    input  dflt_rvalid, dflt_rlast
  );
endinterface

// File: rtl/axi_read_scheduler.sv
// rtl/axi_read_scheduler.sv - read-side sequencer for a 2x2 AXI interconnect with default slave
//
// Purpose: round-robin arbitration of M0/M1 AR requests, address decode to
// S0/S1/default slave, one read transaction in flight until RLAST.
// Ports:
//   ACLK     - clock
//   ARESETn  - asynchronous active-low reset
//   bus      - handshake inputs and select/gating strobes (slave modport)
module axi_read_scheduler #(
  parameter int               ADDR_W      = 32,
  parameter int               LEN_W       = 4,
  parameter logic [ADDR_W-1:0] S0_BASE    = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] S1_BASE    = 32'h0001_0000,
  parameter int               REGION_BITS = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_read_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DFLT} state_t;

  state_t             state_q, state_d;
  logic               last_gnt_q, last_gnt_d;   // 0 = M0, 1 = M1
  logic               gnt_q, gnt_d;
  logic               r_mst_q, r_mst_d;
  logic [1:0]         dst_q, dst_d;             // 0 = S0, 1 = S1, 2 = default
  logic [1:0]         r_src_q, r_src_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  logic               gnt_sel;
  logic [ADDR_W-1:0]  sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic [1:0]         dst_dec;
  logic               arready_dst, rvalid_dst, rlast_dst, rready_gnt;
  logic               arready_m0, arready_m1;
  logic [1:0]         ar_valid_s;
  logic               dflt_rvalid, dflt_rlast;

  // Arbitration and decode of the candidate request seen in IDLE.
  always_comb begin
    gnt_sel  = (bus.ARVALID_M0 & bus.ARVALID_M1) ? ~last_gnt_q : bus.ARVALID_M1;
    sel_addr = gnt_sel ? bus.ARADDR_M1 : bus.ARADDR_M0;
    sel_len  = gnt_sel ? bus.ARLEN_M1  : bus.ARLEN_M0;
    // Whole-word shifts compare only the region bits; S0 checked first so it wins overlaps.
    if ((sel_addr >> REGION_BITS) == (S0_BASE >> REGION_BITS)) begin
      dst_dec = 2'd0;
    end else if ((sel_addr >> REGION_BITS) == (S1_BASE >> REGION_BITS)) begin
      dst_dec = 2'd1;
    end else begin
      dst_dec = 2'd2;
    end
  end

  // Handshakes of the registered destination slave and granted master.
  always_comb begin
    arready_dst = dst_q[0] ? bus.ARREADY_S1 : bus.ARREADY_S0;
    rvalid_dst  = dst_q[0] ? bus.RVALID_S1  : bus.RVALID_S0;
    rlast_dst   = dst_q[0] ? bus.RLAST_S1   : bus.RLAST_S0;
    rready_gnt  = gnt_q    ? bus.RREADY_M1  : bus.RREADY_M0;
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_d       = gnt_q;
    r_mst_d     = r_mst_q;
    dst_d       = dst_q;
    r_src_d     = r_src_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    arready_m0  = 1'b0;
    arready_m1  = 1'b0;
    ar_valid_s  = 2'b00;
    dflt_rvalid = 1'b0;
    dflt_rlast  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ARVALID_M0 | bus.ARVALID_M1) begin
          gnt_d      = gnt_sel;
          last_gnt_d = gnt_sel;
          dst_d      = dst_dec;
          len_d      = sel_len;
          // R mux selects are loaded at grant and then held through IDLE.
          r_mst_d    = gnt_sel;
          r_src_d    = dst_dec;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (dst_q == 2'd2) begin
          // Default slave accepts the address unconditionally in one cycle.
          arready_m0 = ~gnt_q;
          arready_m1 = gnt_q;
          cnt_d      = '0;
          state_d    = DFLT;
        end else begin
          ar_valid_s = dst_q[0] ? 2'b10 : 2'b01;
          arready_m0 = ~gnt_q & arready_dst;
          arready_m1 = gnt_q & arready_dst;
          if (arready_dst) begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rvalid_dst & rready_gnt & rlast_dst) begin
          state_d = IDLE;
        end
      end
      DFLT: begin
        dflt_rvalid = 1'b1;
        dflt_rlast  = (cnt_q == len_q);
        if (rready_gnt) begin
          if (cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;       // M1 so that M0 wins the first tie
      gnt_q      <= 1'b0;
      r_mst_q    <= 1'b0;
      dst_q      <= 2'd0;
      r_src_q    <= 2'd0;
      len_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      r_mst_q    <= r_mst_d;
      dst_q      <= dst_d;
      r_src_q    <= r_src_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ARREADY_M0  = arready_m0;
  assign bus.ARREADY_M1  = arready_m1;
  assign bus.ar_gnt      = (state_q == IDLE) ? 2'b00 : (gnt_q ? 2'b10 : 2'b01);
  assign bus.ar_valid_s  = ar_valid_s;
  assign bus.r_mst       = r_mst_q;
  assign bus.r_src       = r_src_q;
  assign bus.r_busy      = (state_q != IDLE);
  assign bus.dflt_rvalid = dflt_rvalid;
  assign bus.dflt_rlast  = dflt_rlast;

endmodule

// File: doc/axi_read_scheduler.md
# axi_read_scheduler

Sequencing controller for the read side of the two-master (M0, M1) / two-slave (S0, S1) AXI interconnect. Arbitrates AR requests round-robin, decodes the target slave from the address, and drives the select/gating strobes used by the AR and R channel muxes. Holds one read transaction in flight at a time until its RLAST beat completes. Accesses to unmapped addresses are terminated by a built-in default slave that returns a full-length DECERR burst.

## Interface
- ADDR_W, 32, address width; equals `AXI_ADDR_BITS`.
- LEN_W, 4, burst length width; equals `AXI_LEN_BITS`.
- S0_BASE, 32'h0000_0000, S0 region base.
- S1_BASE, 32'h0001_0000, S1 region base.
- REGION_BITS, 16, region size is 2^REGION_BITS; hit when `ADDR[ADDR_W-1:REGION_BITS] == BASE[ADDR_W-1:REGION_BITS]`.

Ports:
- ACLK  in  1  clock; single clock domain.
- ARESETn  in  1  asynchronous, active-low reset.
- ARVALID_M0 / ARVALID_M1  in  1  master read-address valid.
- ARADDR_M0 / ARADDR_M1  in  ADDR_W  master read address.
- ARLEN_M0 / ARLEN_M1  in  LEN_W  master burst length (beats − 1).
- ARREADY_S0 / ARREADY_S1  in  1  slave read-address ready.
- RVALID_S0, RLAST_S0, RVALID_S1, RLAST_S1  in  1  slave read-data valid and last.
- RREADY_M0 / RREADY_M1  in  1  master read-data ready.
- ARREADY_M0 / ARREADY_M1  out  1  read-address ready returned to each master.
- ar_gnt  out  2  one-hot granted master; selects the AR mux.
- ar_valid_s  out  2  ARVALID_S1, ARVALID_S0 gating.
- r_mst  out  1  owner of the R channel (0 = M0, 1 = M1); valid while r_busy.
- r_src  out  2  R mux source: 0 = S0, 1 = S1, 2 = default slave.
- r_busy  out  1  a transaction is in flight.
- dflt_rvalid, dflt_rlast  out  1  default-slave data valid and last; the mux drives RRESP = 2'b11 and RDATA = 0 for this source.

## Operation
- FSM states: IDLE, ADDR, DATA, DFLT.
- IDLE:
  - If any ARVALID_Mx is high, register the grant, decoded destination and ARLEN, then go to ADDR.
  - Round-robin: if both masters request, grant the master that is not last_gnt. A single requester is always granted.
  - last_gnt updates on every grant.
- Decode: S0 hit → dst 0; otherwise S1 hit → dst 1; otherwise dst 2 (default). If S0_BASE equals S1_BASE, S0 wins.
- ADDR with dst 0 or 1:
  - ar_valid_s[dst] = 1.
  - ARREADY_M[gnt] = ARREADY_S[dst], combinational pass-through.
  - On ARREADY_S[dst] high, go to DATA.
  - The granted master keeps ARVALID high per AXI; the FSM does not re-check it.
- ADDR with dst 2: ARREADY_M[gnt] = 1 for exactly one cycle, beat counter cleared, then go to DFLT.
- DATA: r_src = dst, r_mst = gnt. Go to IDLE on the cycle where RVALID_S[dst] & RREADY_M[gnt] & RLAST_S[dst] are all high.
- DFLT:
  - dflt_rvalid = 1.
  - dflt_rlast = (cnt == len).
  - cnt increments on each RREADY_M[gnt] beat.
  - Go to IDLE after the last beat is accepted.
  - cnt is LEN_W bits; it never wraps because the exit happens at cnt == len.
- r_busy = 1 in ADDR, DATA and DFLT.
- The non-granted master sees ARREADY = 0 until the FSM returns to IDLE and grants it.
- Outputs in IDLE: ar_gnt, ar_valid_s, ARREADY_M*, dflt_* and r_busy are 0. r_mst and r_src hold their last values.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, last_gnt = M1 (so M0 wins the first tie).
  - cnt = 0, ar_gnt = 0, r_src = 0, r_mst = 0.
  - All other outputs 0.
- Grant latency: ARVALID sampled high in IDLE at edge N → ar_gnt and ar_valid_s valid from edge N+1.
- Minimum transaction to a real slave, with slave ARREADY already high and a 1-beat burst: IDLE → ADDR → DATA → IDLE. The next grant is registered no earlier than the cycle after the last R beat.
- Default-slave burst of LEN+1 beats with RREADY held high: ADDR (1 cycle) + LEN+1 DFLT cycles.
- A request arriving in the same cycle the RLAST handshake completes is not granted until the FSM is back in IDLE, i.e. one cycle of IDLE gap.
- Reset mid-transaction: immediate return to IDLE with all outputs zero. Slaves are reset by the same ARESETn.

## Test plan
- Reset, then ARVALID_M0 = ARVALID_M1 = 1 simultaneously, both addressing S0 with 1-beat bursts → M0 granted first (ar_gnt = 01), then M1 (ar_gnt = 10).
- M1 reads 0x0001_0040 with ARLEN = 3, S1 ARREADY delayed 2 cycles, RREADY toggling → ar_valid_s = 10 held until ARREADY; ARREADY_M1 pulses once; r_src = 1 and r_mst = 1 for 4 beats; IDLE after RLAST.
- M0 reads unmapped 0x8000_0000 with ARLEN = 2, RREADY_M0 = 1 → ARREADY_M0 high for 1 cycle, then dflt_rvalid for 3 cycles with dflt_rlast on the 3rd; r_src = 2.
- Both masters requesting continuously, 1-beat S0 bursts → grants strictly alternate M0, M1, M0, M1 with no starvation.
- ARESETn asserted mid-DFLT at beat 1 of ARLEN = 7 → all outputs 0 asynchronously; after release the first grant behaves as after power-on (M0 wins a tie).
- ARLEN = 15 burst to the default slave with RREADY low for 5 cycles mid-burst → exactly 16 accepted beats; cnt holds while RREADY is low; dflt_rlast asserted only on beat 16.
